// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the data-memory
// request controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } dmemctl_state_t;

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// Bundle between the MEM-stage pipeline, the data cache and dmem_req_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface dmem_req_ctrl_if;

  logic                 ihit;
  logic                 halt;
  logic                 mem_ren;
  logic                 mem_wen;
  logic                 atomic_in;
  cpu_types_pkg::word_t addr_in;
  cpu_types_pkg::word_t store_in;
  logic                 dhit;
  cpu_types_pkg::word_t dmemload;

  logic                 dmemREN;
  logic                 dmemWEN;
  logic                 datomic;
  cpu_types_pkg::word_t dmemaddr;
  cpu_types_pkg::word_t dmemstore;
  cpu_types_pkg::word_t load_data;
  logic                 pipe_en;
  logic                 mem_busy;
  logic                 timeout_err;

  modport slave (
    input  ihit, halt, mem_ren, mem_wen, atomic_in, addr_in, store_in, dhit, dmemload,
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, load_data,
           pipe_en, mem_busy, timeout_err
  );

  modport master (
    output ihit, halt, mem_ren, mem_wen, atomic_in, addr_in, store_in, dhit, dmemload,
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, load_data,
           pipe_en, mem_busy, timeout_err
  );

endinterface

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data cache request controller: zero-latency request issue,
// request latching while waiting on dhit, pipeline stall control and a watchdog.
module dmem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic            CLK,
  input logic            nRST,
  dmem_req_ctrl_if.slave bus
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(TIMEOUT_CYCLES - 1);

  dmemctl_state_t   state_q, state_d;
  word_t            addr_q, addr_d;
  word_t            store_q, store_d;
  word_t            load_q, load_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;
  logic             atomic_q, atomic_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pending;
  logic in_ren;
  logic in_wen;

  // NOTE: nRST also gates the combinational IDLE path so that every output is
  // 0 while reset is held, even with a request sitting on the inputs.
  assign pending = nRST && (bus.mem_ren || bus.mem_wen) && !bus.halt;
  assign in_wen  = bus.mem_wen;
  assign in_ren  = bus.mem_ren && !bus.mem_wen;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d       = state_q;
    addr_d        = addr_q;
    store_d       = store_q;
    ren_d         = ren_q;
    wen_d         = wen_q;
    atomic_d      = atomic_q;
    load_d        = load_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.datomic   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.pipe_en   = 1'b0;
    bus.mem_busy  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending) begin
          bus.dmemREN   = in_ren;
          bus.dmemWEN   = in_wen;
          bus.datomic   = bus.atomic_in;
          bus.dmemaddr  = bus.addr_in;
          bus.dmemstore = bus.store_in;
          addr_d        = bus.addr_in;
          store_d       = bus.store_in;
          ren_d         = in_ren;
          wen_d         = in_wen;
          atomic_d      = bus.atomic_in;
          if (bus.dhit) begin
            if (!in_wen || bus.atomic_in) load_d = bus.dmemload;
            bus.pipe_en = bus.ihit;
            state_d     = bus.ihit ? IDLE : HOLD;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
          end
        end else begin
          bus.pipe_en = nRST && bus.ihit && !bus.halt;
        end
      end

      ACCESS: begin
        // Inputs are ignored here; the cache sees only the latched request.
        bus.mem_busy  = 1'b1;
        bus.dmemREN   = ren_q;
        bus.dmemWEN   = wen_q;
        bus.datomic   = atomic_q;
        bus.dmemaddr  = addr_q;
        bus.dmemstore = store_q;
        if (bus.dhit) begin
          if (!wen_q || atomic_q) load_d = bus.dmemload;
          bus.pipe_en = bus.ihit;
          state_d     = bus.ihit ? IDLE : HOLD;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_ERR) timeout_d = 1'b1;
        end
      end

      HOLD: begin
        // Data already returned; wait for the fetch side before advancing.
        bus.pipe_en = bus.ihit;
        if (bus.ihit) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      atomic_q  <= 1'b0;
      load_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      atomic_q  <= atomic_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.load_data   = load_q;
  assign bus.timeout_err = timeout_q;

endmodule
